burst_ram_arbiter: RTL and testbench
====================================

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_BITWIDTH, default 4: width of RAM address in 8-byte words.
REQ-002 SHALL have parameter BURST_COUNT, default 4: 64-bit beats per read or write burst; legal values 1..16.
REQ-003 SHALL have one clock and a synchronous active-high reset. Port clk, input, 1, rising-edge clock. Port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have, for each requester N in {0,1}, input mN_cmd (1): 0 read, 1 write.
REQ-005 SHALL have input mN_cmd_en (1): level request, held with cmd/addr stable until acknowledged.
REQ-006 SHALL have input mN_addr (DEPTH_BITWIDTH) and input mN_wr_data (64).
REQ-007 SHALL have input mN_data_mask (8).
REQ-008 SHALL have output mN_ack (1): one-cycle pulse; the command is issued to the RAM this cycle.
REQ-009 SHALL have output mN_rd_data (64) and output mN_rd_data_valid (1).
REQ-010 SHALL have RAM-side outputs br_cmd (1), br_cmd_en (1), br_addr (DEPTH_BITWIDTH), br_wr_data (64) and br_data_mask (8).
REQ-011 SHALL have RAM-side inputs br_rd_data (64), br_rd_data_valid (1), br_init_calib (1) and br_busy (1).

Function
REQ-012 SHALL implement FSM states WAIT_CALIB, IDLE, WRITE, READ.
REQ-013 SHALL move WAIT_CALIB -> IDLE on the first cycle br_init_calib=1; no ack is issued in WAIT_CALIB.
REQ-014 In IDLE with br_busy=0 and at least one mN_cmd_en=1, SHALL grant exactly one port combinationally, in the same cycle.
REQ-015 On grant, SHALL drive mN_ack=1 and br_cmd_en=1, and forward that port's cmd, addr, wr_data and data_mask to br_*.
REQ-016 In IDLE with br_busy=1, SHALL issue no ack, hold requests pending, and keep br_cmd_en=0.
REQ-017 On a write grant, SHALL treat the ack cycle as beat 0 and enter WRITE when BURST_COUNT>1; when BURST_COUNT=1, SHALL stay in IDLE.
REQ-018 In WRITE, SHALL forward the owner's wr_data and data_mask for BURST_COUNT-1 further cycles, then return to IDLE.
REQ-019 On a read grant, SHALL enter READ, count br_rd_data_valid beats, and return to IDLE on the cycle after beat BURST_COUNT.
REQ-020 SHALL drive mN_rd_data = br_rd_data unconditionally for both ports, and drive mN_rd_data_valid = br_rd_data_valid only for the READ owner.
REQ-021 SHALL ignore br_rd_data_valid outside READ: not forwarded, not counted.
REQ-022 SHALL make the beat counter $clog2(BURST_COUNT)+1 bits wide and clear it on every grant, with no wrap within a burst.
REQ-023 SHALL keep requests from the non-owner pending during WRITE/READ, with no ack; earliest grant is the first IDLE cycle after completion.
REQ-024 SHALL keep br_cmd_en=0 outside the grant cycle, and keep br_cmd, br_addr, br_wr_data and br_data_mask at 0 when there is no grant and no WRITE.
REQ-025 SHALL allow back-to-back bursts: completion plus new grant in consecutive cycles, with no idle bubble beyond the IDLE cycle.

Reset
REQ-026 On rst=1, SHALL go to WAIT_CALIB, zero the beat counter, and set the priority pointer to port 0.
REQ-027 During and after reset until a grant, all outputs SHALL be 0.
REQ-028 Reset mid-burst SHALL abandon the burst; in-flight read beats are not forwarded.
REQ-029 rst SHALL dominate all other inputs in the same cycle.

Configuration
REQ-030 With macro BURST_RAM_ARBITER_ROUND_ROBIN_EN defined, on simultaneous requests SHALL grant the port not granted last, and update the pointer on every grant.
REQ-031 Without BURST_RAM_ARBITER_ROUND_ROBIN_EN, SHALL use fixed priority with port 0 always winning; port 1 is served only when port 0 is not requesting.

Structure
REQ-032 Package burst_ram_arbiter_pkg SHALL hold the FSM state enum, the port-index typedef, and the CMD_READ=0 and CMD_WRITE=1 constants.
REQ-033 Sub-module rr_pick2 SHALL provide the combinational two-requester pick (requests, pointer -> grant index, valid); the macro selects the pointer logic only.

Verification
REQ-034 Hold br_init_calib=0 for 10 cycles with m0 requesting read addr 4 -> no ack, br_cmd_en=0; calib=1 -> m0_ack on the first IDLE cycle, br_addr=4, br_cmd=0.
REQ-035 m0 reads addr 2 while m1 requests write addr 8 in the same cycle -> m1_ack is withheld until m0 receives 4 valid beats; m1_ack then occurs in the first cycle after, in IDLE, and m1_rd_data_valid stays 0 throughout.
REQ-036 m1 writes addr 8 with beats 0x11..0x44 -> br_wr_data=0x11,0x22,0x33,0x44 on 4 consecutive cycles starting at the ack cycle, and br_cmd_en=1 only in the first.
REQ-037 Both ports request continuously, round robin enabled -> acks alternate m0,m1,m0,m1; with the macro undefined -> m0 only.
REQ-038 br_busy=1 while both request -> no ack; br_busy falls -> one ack the same cycle.
REQ-039 rst pulsed after 2 of 4 read beats -> state WAIT_CALIB, all outputs 0, and the remaining beats are not forwarded.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-port burst RAM arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        IDLE       = 2'd1,
        WRITE      = 2'd2,
        READ       = 2'd3
    } arb_state_t;

    typedef logic port_idx_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_rr_pick2.sv
// Combinational two-requester pick: a lone requester wins, a tie goes to the
// port named by the priority pointer.
module rr_pick2
    import burst_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  prio,
    output port_idx_t  grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = prio;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-port burst RAM arbiter. Define BURST_RAM_ARBITER_ROUND_ROBIN_EN for
// round-robin tie breaking; otherwise port 0 has fixed priority.
//
// state      | meaning
// WAIT_CALIB | RAM not calibrated, no grants
// IDLE       | grant one pending request when RAM not busy
// WRITE      | forwarding owner's remaining write beats
// READ       | forwarding read beats to owner until burst complete
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_cmd,
    input  logic                      m0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
    input  logic [63:0]               m0_wr_data,
    input  logic [7:0]                m0_data_mask,
    output logic                      m0_ack,
    output logic [63:0]               m0_rd_data,
    output logic                      m0_rd_data_valid,
    input  logic                      m1_cmd,
    input  logic                      m1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
    input  logic [63:0]               m1_wr_data,
    input  logic [7:0]                m1_data_mask,
    output logic                      m1_ack,
    output logic [63:0]               m1_rd_data,
    output logic                      m1_rd_data_valid,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_init_calib,
    input  logic                      br_busy
);

    localparam int CNT_W = $clog2(BURST_COUNT) + 1;
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((BURST_COUNT > 1) ? BURST_COUNT - 2 : 0);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    port_idx_t        owner, owner_nxt, prio, pick_idx;
    logic             pick_valid, grant;

    logic                      sel_cmd;
    logic [DEPTH_BITWIDTH-1:0] sel_addr;
    logic [63:0]               sel_wr_data, own_wr_data;
    logic [7:0]                sel_mask, own_mask;

    rr_pick2 u_pick (
        .req         ({m1_cmd_en, m0_cmd_en}),
        .prio        (prio),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign sel_cmd     = pick_idx ? m1_cmd       : m0_cmd;
    assign sel_addr    = pick_idx ? m1_addr      : m0_addr;
    assign sel_wr_data = pick_idx ? m1_wr_data   : m0_wr_data;
    assign sel_mask    = pick_idx ? m1_data_mask : m0_data_mask;
    assign own_wr_data = owner    ? m1_wr_data   : m0_wr_data;
    assign own_mask    = owner    ? m1_data_mask : m0_data_mask;

    assign m0_rd_data = br_rd_data;
    assign m1_rd_data = br_rd_data;

    always_comb begin
        state_nxt        = state;
        beat_cnt_nxt     = beat_cnt;
        owner_nxt        = owner;
        m0_ack           = 1'b0;
        m1_ack           = 1'b0;
        m0_rd_data_valid = 1'b0;
        m1_rd_data_valid = 1'b0;
        br_cmd           = CMD_READ;
        br_cmd_en        = 1'b0;
        br_addr          = '0;
        br_wr_data       = '0;
        br_data_mask     = '0;
        // Outputs are gated by rst so reset wins even before the edge lands.
        grant = !rst && (state == IDLE) && !br_busy && pick_valid;

        unique case (state)
            WAIT_CALIB: begin
                if (br_init_calib) state_nxt = IDLE;
            end
            IDLE: begin
                if (grant) begin
                    m0_ack       = !pick_idx;
                    m1_ack       = pick_idx;
                    br_cmd_en    = 1'b1;
                    br_cmd       = sel_cmd;
                    br_addr      = sel_addr;
                    br_wr_data   = sel_wr_data;
                    br_data_mask = sel_mask;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    if (sel_cmd == CMD_WRITE) begin
                        state_nxt = (BURST_COUNT > 1) ? WRITE : IDLE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                if (!rst) begin
                    br_cmd       = CMD_WRITE;
                    br_wr_data   = own_wr_data;
                    br_data_mask = own_mask;
                end
                beat_cnt_nxt = beat_cnt + CNT_ONE;
                if (beat_cnt == WR_LAST) state_nxt = IDLE;
            end
            READ: begin
                if (br_rd_data_valid) begin
                    m0_rd_data_valid = !rst && !owner;
                    m1_rd_data_valid = !rst && owner;
                    beat_cnt_nxt     = beat_cnt + CNT_ONE;
                    if (beat_cnt == RD_LAST) state_nxt = IDLE;
                end
            end
            default: state_nxt = WAIT_CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_CALIB;
            beat_cnt <= '0;
            owner    <= 1'b0;
            prio     <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            owner    <= owner_nxt;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
            if (grant) prio <= ~pick_idx;
`else
            prio     <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed self-checking bench for burst_ram_arbiter (DEPTH_BITWIDTH=4, BURST_COUNT=4).
module tb_burst_ram_arbiter;

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cmd, m0_cmd_en, m1_cmd, m1_cmd_en;
    logic [3:0]  m0_addr, m1_addr;
    logic [63:0] m0_wr_data, m1_wr_data;
    logic [7:0]  m0_data_mask, m1_data_mask;
    logic        m0_ack, m1_ack, m0_rd_data_valid, m1_rd_data_valid;
    logic [63:0] m0_rd_data, m1_rd_data;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic [7:0]  br_data_mask;
    logic        br_rd_data_valid, br_init_calib, br_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(4), .BURST_COUNT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd(m0_cmd), .m0_cmd_en(m0_cmd_en), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_data_mask(m0_data_mask), .m0_ack(m0_ack),
        .m0_rd_data(m0_rd_data), .m0_rd_data_valid(m0_rd_data_valid),
        .m1_cmd(m1_cmd), .m1_cmd_en(m1_cmd_en), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_data_mask(m1_data_mask), .m1_ack(m1_ack),
        .m1_rd_data(m1_rd_data), .m1_rd_data_valid(m1_rd_data_valid),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_init_calib(br_init_calib), .br_busy(br_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {m0_ack, m1_ack, m0_rd_data_valid, m1_rd_data_valid, br_cmd, br_cmd_en}, 0);
        chk({tag, "_bus"}, {br_addr, br_data_mask}, 0);
        chk({tag, "_wdata"}, br_wr_data, 0);
        chk({tag, "_rdata"}, m0_rd_data | m1_rd_data, 0);
    endtask

    initial begin
        rst = 1'b1; br_init_calib = 1'b0; br_busy = 1'b0;
        br_rd_data = '0; br_rd_data_valid = 1'b0;
        m0_cmd = 1'b0; m0_cmd_en = 1'b0; m0_addr = '0; m0_wr_data = '0; m0_data_mask = '0;
        m1_cmd = 1'b0; m1_cmd_en = 1'b0; m1_addr = '0; m1_wr_data = '0; m1_data_mask = '0;

        // Reset state, then rst dominating calib and an active request
        repeat (3) tick();
        #1 chk_all_zero("reset");
        br_init_calib = 1'b1; m0_cmd_en = 1'b1; m0_addr = 4'd4;
        #1 chk("rst_dominates_ack", m0_ack, 0);
        chk("rst_dominates_cmd_en", br_cmd_en, 0);
        tick();
        br_init_calib = 1'b0; rst = 1'b0;

        // Calibration wait with m0 reading addr 4
        for (int i = 0; i < 10; i++) begin
            tick();
            #1 chk("calib_wait_ack", m0_ack, 0);
            chk("calib_wait_cmd_en", br_cmd_en, 0);
        end
        br_init_calib = 1'b1;
        #1 chk("calib_seen_no_ack", m0_ack, 0);
        tick();
        #1 chk("first_idle_ack", m0_ack, 1);
        chk("first_idle_cmd_en", br_cmd_en, 1);
        chk("first_idle_addr", br_addr, 4);
        chk("first_idle_cmd", br_cmd, 0);
        tick();
        m0_cmd_en = 1'b0;
        #1 chk("post_ack_quiet", {m0_ack, br_cmd_en, br_addr}, 0);
        for (int i = 0; i < 4; i++) begin
            br_rd_data_valid = 1'b1; br_rd_data = 64'hA0 + 64'(i);
            #1 chk("rd1_valid", m0_rd_data_valid, 1);
            chk("rd1_data", m0_rd_data, 64'hA0 + 64'(i));
            chk("rd1_m1_valid", m1_rd_data_valid, 0);
            tick();
        end
        br_rd_data_valid = 1'b0; br_rd_data = '0;

        // Reset (pointer back to port 0), then simultaneous m0 read / m1 write
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_cmd = 1'b0; m0_addr = 4'd2; m0_cmd_en = 1'b1;
        m1_cmd = 1'b1; m1_addr = 4'd8; m1_cmd_en = 1'b1;
        m1_wr_data = 64'h11; m1_data_mask = 8'hFF;
        #1 chk("wait_calib_no_ack", {m0_ack, m1_ack}, 0);
        tick();
        #1 chk("tie_m0_ack", m0_ack, 1);
        chk("tie_m1_ack", m1_ack, 0);
        chk("tie_addr", br_addr, 2);
        chk("tie_cmd", br_cmd, 0);
        tick();
        m0_cmd_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("read_gap_m1_ack", m1_ack, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            br_rd_data_valid = 1'b1; br_rd_data = 64'hB0 + 64'(i);
            #1 chk("rd2_m0_valid", m0_rd_data_valid, 1);
            chk("rd2_m1_valid", m1_rd_data_valid, 0);
            chk("rd2_m1_ack", m1_ack, 0);
            tick();
        end
        br_rd_data_valid = 1'b0; br_rd_data = '0;
        #1 chk("m1_ack_after_read", m1_ack, 1);
        chk("wr_beat0_cmd_en", br_cmd_en, 1);
        chk("wr_beat0_cmd", br_cmd, 1);
        chk("wr_beat0_addr", br_addr, 8);
        chk("wr_beat0_data", br_wr_data, 64'h11);
        tick();
        m1_cmd_en = 1'b0; m1_wr_data = 64'h22; m1_data_mask = 8'h0F;
        #1 chk("wr_beat1_data", br_wr_data, 64'h22);
        chk("wr_beat1_mask", br_data_mask, 8'h0F);
        chk("wr_beat1_cmd_en", br_cmd_en, 0);
        tick();
        m1_wr_data = 64'h33; br_rd_data_valid = 1'b1;
        #1 chk("wr_beat2_data", br_wr_data, 64'h33);
        chk("stray_valid_ignored", {m0_rd_data_valid, m1_rd_data_valid}, 0);
        tick();
        m1_wr_data = 64'h44; br_rd_data_valid = 1'b0;
        #1 chk("wr_beat3_data", br_wr_data, 64'h44);
        chk("wr_beat3_cmd_en", br_cmd_en, 0);
        tick();
        m1_wr_data = 64'h55;
        #1 chk("wr_done_data", br_wr_data, 0);
        chk("wr_done_cmd_en", br_cmd_en, 0);

        // Both ports continuously requesting writes
        m0_cmd = 1'b1; m1_cmd = 1'b1; m0_cmd_en = 1'b1; m1_cmd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("contend_m0_ack", m0_ack, RR ? ((k % 2) == 0) : 1'b1);
            chk("contend_m1_ack", m1_ack, RR ? ((k % 2) == 1) : 1'b0);
            tick();
            #1 chk("contend_write_cmd_en", br_cmd_en, 0);
            repeat (3) tick();
        end

        // RAM busy while both request
        br_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_no_ack", {m0_ack, m1_ack, br_cmd_en}, 0);
            tick();
        end
        br_busy = 1'b0;
        #1 chk("busy_release_ack", {m1_ack, m0_ack}, 2'b01);
        chk("busy_release_cmd_en", br_cmd_en, 1);
        tick();
        m0_cmd_en = 1'b0; m1_cmd_en = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a 4-beat read
        m0_cmd = 1'b0; m0_addr = 4'd5; m0_cmd_en = 1'b1;
        #1 chk("rd3_ack", m0_ack, 1);
        tick();
        m0_cmd_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            br_rd_data_valid = 1'b1; br_rd_data = 64'hC0 + 64'(i);
            #1 chk("rd3_valid", m0_rd_data_valid, 1);
            tick();
        end
        br_rd_data = '0; rst = 1'b1; br_init_calib = 1'b0; m0_cmd_en = 1'b1;
        #1 chk_all_zero("midburst_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk_all_zero("after_rst");
            tick();
        end
        br_rd_data_valid = 1'b0; m0_cmd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
